// File: rtl/tpu_cmd_dispatcher.sv
// TPU command dispatcher: takes the queue head descriptor, sequences optional
// DMA prefetch, array compute and optional DMA evict, then pops or halts the queue.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   exec_valid, exec_cmd    queue head valid and 128-bit descriptor
//   exec_done, exec_error   one-cycle completion / failure pulses
//   dma_req/dir/addr/wgt_addr, dma_ack, dma_err
//                           DMA request (held until ack) and its response
//   arr_start/mode/k/m_sel/n_sel/cfg, arr_done
//                           systolic-array launch and completion
//   abort                   software abort
//   busy, last_err, cmds_done
//                           status: not idle, sticky error code, done counter
module tpu_cmd_dispatcher #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exec_valid,
    input  logic [127:0]     exec_cmd,
    output logic             exec_done,
    output logic             exec_error,
    output logic             dma_req,
    output logic             dma_dir,
    output logic [31:0]      dma_addr,
    output logic [15:0]      dma_wgt_addr,
    input  logic             dma_ack,
    input  logic             dma_err,
    output logic             arr_start,
    output logic             arr_mode,
    output logic [7:0]       arr_k,
    output logic [3:0]       arr_m_sel,
    output logic [3:0]       arr_n_sel,
    output logic [2:0]       arr_cfg,
    input  logic             arr_done,
    input  logic             abort,
    output logic             busy,
    output logic [2:0]       last_err,
    output logic [CNT_W-1:0] cmds_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_GEMM   = 8'h00;
    localparam logic [7:0] OP_REDUCE = 8'h01;
    localparam logic [7:0] OP_NOP    = 8'hFF;

    localparam logic [2:0] E_OPCODE  = 3'd1;
    localparam logic [2:0] E_KTILE   = 3'd2;
    localparam logic [2:0] E_TIMEOUT = 3'd3;
    localparam logic [2:0] E_DMA     = 3'd4;
    localparam logic [2:0] E_ABORT   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_LOAD,
        S_ISSUE,
        S_COMPUTE,
        S_STORE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [127:0]  cmd_q;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    err_nxt;
    logic          timed_out;
    logic          in_wait;

    logic [7:0]    opcode;
    logic          dma_en;
    logic [7:0]    k_tile;
    logic          unused_bits;

    assign opcode = cmd_q[127:120];
    assign dma_en = cmd_q[117];
    assign k_tile = cmd_q[15:8];

    // chain and irq_en belong to the queue; reserved bits carry nothing
    assign unused_bits = ^{cmd_q[119:118], cmd_q[113:96]};

    assign in_wait   = (state == S_LOAD) || (state == S_COMPUTE) ||
                       (state == S_STORE);
    // The entry cycle counts as the first, so this fires on the last one
    assign timed_out = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        err_nxt   = 3'd0;
        unique case (state)
            S_IDLE: begin
                if (exec_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (abort) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_ABORT;
                end else if (opcode == OP_NOP) begin
                    state_nxt = S_DONE;
                end else if (opcode != OP_GEMM && opcode != OP_REDUCE) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_OPCODE;
                end else if (k_tile == 8'd0) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_KTILE;
                end else begin
                    state_nxt = dma_en ? S_LOAD : S_ISSUE;
                end
            end
            S_LOAD, S_STORE: begin
                if (abort) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_ABORT;
                end else if (!exec_valid) begin
                    state_nxt = S_IDLE;
                end else if (dma_err) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_DMA;
                end else if (dma_ack) begin
                    state_nxt = (state == S_LOAD) ? S_ISSUE : S_DONE;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_TIMEOUT;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_ABORT;
                end else if (!exec_valid) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (abort) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_ABORT;
                end else if (!exec_valid) begin
                    state_nxt = S_IDLE;
                end else if (arr_done) begin
                    state_nxt = dma_en ? S_STORE : S_DONE;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                    err_nxt   = E_TIMEOUT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            tmo_cnt   <= '0;
            last_err  <= 3'd0;
            cmds_done <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && exec_valid) begin
                cmd_q <= exec_cmd;
            end
            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (in_wait) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            // Code is visible alongside the exec_error pulse
            if (state_nxt == S_ERR && state != S_ERR) begin
                last_err <= err_nxt;
            end
            if (state == S_DONE) begin
                cmds_done <= cmds_done + CNT_W'(1);
            end
        end
    end

    assign exec_done    = (state == S_DONE);
    assign exec_error   = (state == S_ERR);
    assign busy         = (state != S_IDLE);
    assign dma_req      = (state == S_LOAD) || (state == S_STORE);
    assign dma_dir      = (state == S_STORE);
    assign dma_addr     = (state == S_STORE) ? cmd_q[95:64] : cmd_q[63:32];
    assign dma_wgt_addr = cmd_q[31:16];
    assign arr_start    = (state == S_ISSUE);
    assign arr_mode     = (opcode == OP_REDUCE);
    assign arr_k        = k_tile;
    assign arr_m_sel    = cmd_q[7:4];
    assign arr_n_sel    = cmd_q[3:0];
    assign arr_cfg      = cmd_q[116:114];

endmodule

// File: tb/tb_tpu_cmd_dispatcher.sv
// Bench for tpu_cmd_dispatcher: descriptor vector table plus hand-written
// sequences for back-to-back, cancel, abort and reset corner cases.
module tb_tpu_cmd_dispatcher;

    logic         clk;
    logic         rst_n;
    logic         exec_valid;
    logic [127:0] exec_cmd;
    logic         exec_done;
    logic         exec_error;
    logic         dma_req;
    logic         dma_dir;
    logic [31:0]  dma_addr;
    logic [15:0]  dma_wgt_addr;
    logic         dma_ack;
    logic         dma_err;
    logic         arr_start;
    logic         arr_mode;
    logic [7:0]   arr_k;
    logic [3:0]   arr_m_sel;
    logic [3:0]   arr_n_sel;
    logic [2:0]   arr_cfg;
    logic         arr_done;
    logic         abort;
    logic         busy;
    logic [2:0]   last_err;
    logic [15:0]  cmds_done;

    tpu_cmd_dispatcher #(
        .TIMEOUT_CYCLES(16),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .exec_valid(exec_valid),
        .exec_cmd(exec_cmd),
        .exec_done(exec_done),
        .exec_error(exec_error),
        .dma_req(dma_req),
        .dma_dir(dma_dir),
        .dma_addr(dma_addr),
        .dma_wgt_addr(dma_wgt_addr),
        .dma_ack(dma_ack),
        .dma_err(dma_err),
        .arr_start(arr_start),
        .arr_mode(arr_mode),
        .arr_k(arr_k),
        .arr_m_sel(arr_m_sel),
        .arr_n_sel(arr_n_sel),
        .arr_cfg(arr_cfg),
        .arr_done(arr_done),
        .abort(abort),
        .busy(busy),
        .last_err(last_err),
        .cmds_done(cmds_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;

    // Responder settings: ack/err in the (ack_dly+1)th req cycle;
    // arr_done arr_dly cycles after arr_start (0 = never)
    int ack_dly = 0;
    int arr_dly = 1;
    bit err_en  = 0;
    int req_cnt = 0;
    int since   = 0;
    bit armed   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt  = 0;
            armed    = 0;
            dma_ack  = 1'b0;
            dma_err  = 1'b0;
            arr_done = 1'b0;
        end else begin
            req_cnt  = dma_req ? req_cnt + 1 : 0;
            dma_ack  = dma_req && (req_cnt == ack_dly + 1);
            dma_err  = dma_req && err_en && (req_cnt == ack_dly + 1);
            if (arr_start) begin
                armed = 1;
                since = 0;
            end else if (armed) begin
                since = since + 1;
            end
            if (!busy) armed = 0;
            arr_done = armed && (arr_dly != 0) && (since == arr_dly);
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (exec_done || exec_error) begin
            chk("done_err_exclusive", {exec_done, exec_error}, 2'b10 >> exec_error);
        end
    endtask

    function automatic logic [127:0] mk(
        input logic [7:0] op, input logic [1:0] ci, input logic dma,
        input logic [2:0] cfg, input logic [31:0] outb, input logic [31:0] actb,
        input logic [15:0] wgt, input logic [7:0] k, input logic [3:0] m,
        input logic [3:0] n);
        return {op, ci, dma, cfg, 18'h0, outb, actb, wgt, k, m, n};
    endfunction

    typedef struct {
        string        name;
        logic [127:0] cmd;
        int           ack_dly;
        int           arr_dly;
        bit           err_en;
        bit           exp_done;
        int           exp_cyc;
        int           exp_starts;
        int           exp_reqs;
        logic [31:0]  exp_ld;
        logic [15:0]  exp_wgt;
        logic [31:0]  exp_st;
        logic [7:0]   exp_k;
        logic         exp_mode;
        logic [2:0]   exp_cfg;
        logic [3:0]   exp_m;
        logic [3:0]   exp_n;
        logic [2:0]   exp_le;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int          starts = 0;
        int          reqs   = 0;
        int          pcyc   = 0;
        bit          pdone  = 0;
        bit          prev_req = 0;
        logic [31:0] ld  = '0;
        logic [31:0] st  = '0;
        logic [15:0] wgt = '0;
        logic [7:0]  k   = '0;
        logic        mode = 1'b0;
        logic [2:0]  cfg = '0;
        logic [3:0]  m   = '0;
        logic [3:0]  n   = '0;
        ack_dly    = v.ack_dly;
        arr_dly    = v.arr_dly;
        err_en     = v.err_en;
        exec_cmd   = v.cmd;
        exec_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            // Head contents after accept must not leak into outputs
            if (cyc == 1) exec_cmd = {4{32'hA5C3_5A3C}};
            if (arr_start) begin
                starts++;
                k = arr_k; mode = arr_mode; cfg = arr_cfg;
                m = arr_m_sel; n = arr_n_sel;
            end
            if (dma_req && !prev_req) begin
                reqs++;
                if (reqs == 1) begin
                    ld = dma_addr; wgt = dma_wgt_addr;
                    chk({v.name, "/ld_dir"}, dma_dir, 1'b0);
                end else begin
                    st = dma_addr;
                    chk({v.name, "/st_dir"}, dma_dir, 1'b1);
                end
            end
            prev_req = dma_req;
            if (exec_done || exec_error) begin
                pdone = exec_done;
                pcyc  = cyc;
                break;
            end
        end
        exec_valid = 1'b0;
        chk({v.name, "/pulse_seen"}, pcyc != 0, 1'b1);
        chk({v.name, "/pulse_kind"}, pdone, v.exp_done);
        chk({v.name, "/pulse_cyc"}, pcyc, v.exp_cyc);
        chk({v.name, "/starts"}, starts, v.exp_starts);
        chk({v.name, "/reqs"}, reqs, v.exp_reqs);
        if (v.exp_starts > 0) begin
            chk({v.name, "/arr_k"}, k, v.exp_k);
            chk({v.name, "/arr_mode"}, mode, v.exp_mode);
            chk({v.name, "/arr_cfg"}, cfg, v.exp_cfg);
            chk({v.name, "/arr_msel"}, m, v.exp_m);
            chk({v.name, "/arr_nsel"}, n, v.exp_n);
        end
        if (v.exp_reqs > 0) begin
            chk({v.name, "/ld_addr"}, ld, v.exp_ld);
            chk({v.name, "/wgt_addr"}, wgt, v.exp_wgt);
        end
        if (v.exp_reqs > 1) chk({v.name, "/st_addr"}, st, v.exp_st);
        step();
        chk({v.name, "/idle"}, busy, 1'b0);
        chk({v.name, "/last_err"}, last_err, v.exp_le);
        chk({v.name, "/cmds_done"}, cmds_done, v.exp_cnt);
    endtask

    function automatic vec_t mkv(
        input string nm, input logic [127:0] c, input int ad, input int rd,
        input bit ee, input bit ed, input int ec, input int es, input int er,
        input logic [31:0] eld, input logic [15:0] ew, input logic [31:0] est,
        input logic [7:0] ek, input logic em, input logic [2:0] ecf,
        input logic [3:0] emm, input logic [3:0] enn, input logic [2:0] ele,
        input int ecn);
        vec_t v;
        v.name = nm; v.cmd = c; v.ack_dly = ad; v.arr_dly = rd; v.err_en = ee;
        v.exp_done = ed; v.exp_cyc = ec; v.exp_starts = es; v.exp_reqs = er;
        v.exp_ld = eld; v.exp_wgt = ew; v.exp_st = est; v.exp_k = ek;
        v.exp_mode = em; v.exp_cfg = ecf; v.exp_m = emm; v.exp_n = enn;
        v.exp_le = ele; v.exp_cnt = ecn;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int          nd;
        int          ns;
        int          dc[2];
        logic [7:0]  ks[2];
        logic        ms[2];
        logic [127:0] cmd_a;
        logic [127:0] cmd_b;
        bit          found;

        vecs[0] = mkv("nop", mk(8'hFF, 2'b00, 1'b1, 3'b111, 32'h1, 32'h2, 16'h3, 8'h0, 4'h1, 4'h1),
                      0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1);
        vecs[1] = mkv("gemm", mk(8'h00, 2'b11, 1'b0, 3'b010, 32'h0, 32'h0, 16'h0, 8'd5, 4'd3, 4'd12),
                      0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 8'd5, 1'b0, 3'b010, 4'd3, 4'd12, 3'd0, 2);
        vecs[2] = mkv("reduce", mk(8'h01, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 8'hFF, 4'd15, 4'd0),
                      0, 3, 0, 1, 6, 1, 0, 0, 0, 0, 8'hFF, 1'b1, 3'b000, 4'd15, 4'd0, 3'd0, 3);
        vecs[3] = mkv("gemm_dma", mk(8'h00, 2'b00, 1'b1, 3'b101, 32'h2000, 32'h1000, 16'h0040, 8'd9, 4'd1, 4'd2),
                      3, 5, 0, 1, 16, 1, 2, 32'h1000, 16'h0040, 32'h2000, 8'd9, 1'b0, 3'b101, 4'd1, 4'd2, 3'd0, 4);
        vecs[4] = mkv("bad_op", mk(8'h07, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 8'd4, 4'd0, 4'd0),
                      0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 4);
        vecs[5] = mkv("k_zero", mk(8'h00, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0, 16'h0, 8'd0, 4'd0, 4'd0),
                      0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 4);
        vecs[6] = mkv("dma_err", mk(8'h00, 2'b00, 1'b1, 3'b000, 32'h0, 32'hDEAD_0000, 16'h1234, 8'd2, 4'd0, 4'd0),
                      0, 1, 1, 0, 3, 0, 1, 32'hDEAD_0000, 16'h1234, 0, 0, 0, 0, 0, 0, 3'd4, 4);
        vecs[7] = mkv("timeout", mk(8'h00, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 8'd1, 4'd0, 4'd0),
                      0, 0, 0, 0, 19, 1, 0, 0, 0, 0, 8'd1, 1'b0, 3'b000, 4'd0, 4'd0, 3'd3, 4);

        rst_n      = 1'b0;
        exec_valid = 1'b0;
        exec_cmd   = '0;
        abort      = 1'b0;
        dma_ack    = 1'b0;
        dma_err    = 1'b0;
        arr_done   = 1'b0;
        #1;
        chk("reset_outputs",
            {exec_done, exec_error, dma_req, dma_dir, dma_addr, dma_wgt_addr,
             arr_start, arr_mode, arr_k, arr_m_sel, arr_n_sel, arr_cfg, busy,
             last_err, cmds_done}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: valid held high, head swapped after the first done
        cmd_a = mk(8'h00, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 8'd3, 4'd1, 4'd1);
        cmd_b = mk(8'h01, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 8'd7, 4'd2, 4'd2);
        ack_dly = 0; arr_dly = 1; err_en = 0;
        nd = 0; ns = 0; dc[0] = 0; dc[1] = 0;
        exec_cmd = cmd_a; exec_valid = 1'b1; cyc = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (arr_start) begin
                if (ns < 2) begin
                    ks[ns] = arr_k;
                    ms[ns] = arr_mode;
                end
                ns++;
            end
            if (exec_done) begin
                if (nd < 2) dc[nd] = cyc;
                nd++;
                if (nd == 1) exec_cmd = cmd_b;
                if (nd == 2) begin
                    exec_valid = 1'b0;
                    break;
                end
            end
        end
        repeat (3) begin
            step();
            if (arr_start) ns++;
            if (exec_done) nd++;
        end
        chk("b2b/dones", nd, 2);
        chk("b2b/starts", ns, 2);
        chk("b2b/done1_cyc", dc[0], 4);
        chk("b2b/done2_cyc", dc[1], 9);
        chk("b2b/k1", ks[0], 8'd3);
        chk("b2b/k2", ks[1], 8'd7);
        chk("b2b/mode1", ms[0], 1'b0);
        chk("b2b/mode2", ms[1], 1'b1);
        chk("b2b/cmds_done", cmds_done, 16'd6);
        chk("b2b/idle", busy, 1'b0);

        // Cancel: valid dropped while in COMPUTE
        ack_dly = 0; arr_dly = 0; err_en = 0;
        exec_cmd = mk(8'h00, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 16'h0, 8'd4, 4'd0, 4'd0);
        exec_valid = 1'b1; cyc = 0; nd = 0;
        repeat (4) begin
            step();
            if (exec_done || exec_error) nd++;
        end
        chk("cancel/busy_in_compute", busy, 1'b1);
        exec_valid = 1'b0;
        step();
        chk("cancel/idle", busy, 1'b0);
        repeat (3) begin
            if (exec_done || exec_error) nd++;
            step();
        end
        chk("cancel/no_pulse", nd, 0);
        chk("cancel/last_err", last_err, 3'd3);
        chk("cancel/cmds_done", cmds_done, 16'd6);

        // Abort while the store request is pending
        ack_dly = 2; arr_dly = 1; err_en = 0;
        exec_cmd = mk(8'h00, 2'b00, 1'b1, 3'b000, 32'h3000, 32'h4000, 16'h0, 8'd6, 4'd0, 4'd0);
        exec_valid = 1'b1; cyc = 0; found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dma_req && dma_dir) begin
                found = 1;
                break;
            end
        end
        chk("abort/store_seen", found, 1'b1);
        chk("abort/store_addr", dma_addr, 32'h3000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        exec_valid = 1'b0;
        chk("abort/error_pulse", exec_error, 1'b1);
        chk("abort/no_done", exec_done, 1'b0);
        chk("abort/req_low", dma_req, 1'b0);
        step();
        chk("abort/last_err", last_err, 3'd5);
        chk("abort/idle", busy, 1'b0);
        chk("abort/cmds_done", cmds_done, 16'd6);

        // Reset asserted while the load request is pending
        ack_dly = 10; arr_dly = 1; err_en = 0;
        exec_cmd = mk(8'h01, 2'b00, 1'b1, 3'b111, 32'h5000, 32'h6000, 16'h77, 8'd8, 4'd3, 4'd4);
        exec_valid = 1'b1; cyc = 0; found = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dma_req) begin
                found = 1;
                break;
            end
        end
        chk("rst/load_seen", found, 1'b1);
        chk("rst/load_addr", dma_addr, 32'h6000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst/outputs_zero",
            {exec_done, exec_error, dma_req, dma_dir, dma_addr, dma_wgt_addr,
             arr_start, arr_mode, arr_k, arr_m_sel, arr_n_sel, arr_cfg, busy,
             last_err, cmds_done}, '0);
        exec_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst/idle_after", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
